lut5_cfg_loader: RTL and testbench
==================================

Name: lut5_cfg_loader

Overview:
- Programmable bank of NUM_LUTS 5-input truth tables (32-bit INIT words) for approximate-arithmetic cells.
- Write side: serial configuration frames loaded through a small FSM.
- Read side: registered lookup port that evaluates any stored table against a 5-bit operand slice.
- Reset loads every entry with the fixed round/saturate function O = I4 | (I3&I2&I1&I0), so the datapath runs unprogrammed.

Parameters:
- NUM_LUTS, 8: number of stored truth tables.
- ADDR_W, 3: table address width; must satisfy 2**ADDR_W >= NUM_LUTS.
- RST_INIT, 32'hFFFF8000: reset truth table for every entry; bit k is the output for input index k = {I4,I3,I2,I1,I0}.

Ports:
- clk  in  1  single clock, all state rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse that opens a configuration frame.
- cfg_sv  in  1  serial bit strobe; cfg_sdi is sampled only when high.
- cfg_sdi  in  1  serial data bit.
- cfg_busy  out  1  high while a frame is in progress (ADDR, DATA or COMMIT).
- cfg_done  out  1  one-cycle pulse when a frame commits.
- cfg_err  out  1  one-cycle pulse on an aborted or invalid frame.
- lk_valid  in  1  lookup request.
- lk_addr  in  ADDR_W  table select.
- lk_in  in  5  operand bits {I4..I0}.
- lk_out  out  1  registered lookup result.
- lk_out_valid  out  1  registered copy of lk_valid.

Behaviour:
- Reset (rst_n low at a clk edge):
  - all entries = RST_INIT; FSM = IDLE.
  - cfg_busy, cfg_done, cfg_err, lk_out, lk_out_valid = 0.
  - Bit counter and shift register cleared.
  - Reset mid-frame discards the partial frame; no entry changes except the reset reload.
- Frame format: ADDR_W address bits, MSB first, then 32 data bits, MSB first (bit 31 first). Bits count only on cycles with cfg_sv=1.
- FSM:
  - IDLE: cfg_start -> ADDR, counter=0. cfg_sv is ignored in IDLE.
  - ADDR: on each cfg_sv, shift cfg_sdi into the address. After ADDR_W bits -> DATA, counter=0.
  - DATA: on each cfg_sv, shift cfg_sdi into the 32-bit shift register. After 32 bits -> COMMIT.
  - COMMIT (exactly one cycle, no sampling):
    - If address < NUM_LUTS: entry written; cfg_done=1 in the following cycle.
    - Otherwise: no write; cfg_err=1 in the following cycle.
    - Then -> IDLE.
- Abort: cfg_start while in ADDR or DATA:
  - partial frame dropped; cfg_err pulses next cycle.
  - FSM restarts in ADDR with counter=0.
  - A cfg_sv in that same cycle is ignored.
  - cfg_start during COMMIT is ignored; the commit completes.
- cfg_busy = 1 in ADDR, DATA and COMMIT.
- Lookup:
  - lk_out <= entry[lk_addr][lk_in] one cycle after the request; lk_out_valid <= lk_valid.
  - lk_out holds its value when lk_valid=0.
  - lk_addr >= NUM_LUTS: lk_out=0 and lk_out_valid still asserts.
  - Same-cycle COMMIT to the addressed entry: the lookup returns the old contents. The new contents are visible from the next cycle.
- Lookups are independent of FSM state; no stall, no back-pressure.

Test Plan:
- Reset defaults: after reset, lookup lk_addr=0 with lk_in=5'b01111 -> lk_out=1; 5'b01110 -> 0; 5'b10000 -> 1; 5'b00000 -> 0. Each result appears one cycle later with lk_out_valid=1.
- Normal frame: cfg_start, address 3'd2, data 32'h00000001, with cfg_sv gaps between bits.
  - cfg_done pulses once, 2 cycles after the last data bit.
  - Lookup addr 2 with lk_in=0 -> 1; lk_in=1 -> 0; addr 0 is unchanged.
- Commit collision: lookup addr 2, lk_in=0 issued in the COMMIT cycle of a frame writing 32'h0 to addr 2 -> returns the old value 1; the next-cycle lookup -> 0.
- Abort: cfg_start, 3 address bits, 10 data bits, then cfg_start again.
  - cfg_err pulses once.
  - A full subsequent frame (addr 5, data 32'hAAAAAAAA) commits; lookup addr 5, lk_in=1 -> 1; lk_in=0 -> 0.
- Invalid address (NUM_LUTS=6, frame addr 3'd7): cfg_err pulses, cfg_done stays 0, and no entry changes.
- Reset mid-DATA: rst_n low after 16 data bits -> cfg_busy=0 and the targeted entry reads RST_INIT; the next cfg_sv bits are ignored until cfg_start.

Source files
------------

// File: rtl/lut5_cfg_loader.sv
// lut5_cfg_loader: serially programmed bank of 5-input truth tables with a registered lookup port
module lut5_cfg_loader #(
    parameter int          NUM_LUTS = 8,
    parameter int          ADDR_W   = 3,
    parameter logic [31:0] RST_INIT = 32'hFFFF8000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_sv,
    input  logic              cfg_sdi,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_addr,
    input  logic [4:0]        lk_in,
    output logic              lk_out,
    output logic              lk_out_valid
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, COMMIT} state_t;

    localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(NUM_LUTS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [4:0]          r_cnt;
    logic [4:0]          w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [31:0]         r_sr;
    logic [31:0]         w_sr_nxt;
    logic                r_done;
    logic                r_err;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic                w_wr;
    logic                w_addr_ok;
    logic                w_last_addr;
    logic                w_last_data;
    logic                w_lk_bit;
    logic [31:0]         r_mem [NUM_LUTS];
    logic                r_lk_out;
    logic                r_lk_out_valid;

    assign w_addr_ok   = {1'b0, r_addr} < LIM;
    assign w_last_addr = r_cnt == 5'(ADDR_W - 1);
    assign w_last_data = r_cnt == 5'd31;

    assign cfg_busy     = r_state != IDLE;
    assign cfg_done     = r_done;
    assign cfg_err      = r_err;
    assign lk_out       = r_lk_out;
    assign lk_out_valid = r_lk_out_valid;

    // Frame sequencing: commit is uninterruptible, cfg_start elsewhere (re)opens a frame
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_sr_nxt    = r_sr;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_wr        = 1'b0;
        if (r_state == COMMIT) begin
            w_state_nxt = IDLE;
            w_wr        = w_addr_ok;
            w_done_nxt  = w_addr_ok;
            w_err_nxt   = !w_addr_ok;
        end else if (cfg_start) begin
            w_state_nxt = ADDR;
            w_cnt_nxt   = 5'd0;
            w_err_nxt   = r_state != IDLE;
        end else if (cfg_sv && r_state == ADDR) begin
            w_addr_nxt  = ADDR_W'({r_addr, cfg_sdi});
            w_cnt_nxt   = w_last_addr ? 5'd0 : r_cnt + 5'd1;
            w_state_nxt = w_last_addr ? DATA : ADDR;
        end else if (cfg_sv && r_state == DATA) begin
            w_sr_nxt    = {r_sr[30:0], cfg_sdi};
            w_cnt_nxt   = w_last_data ? 5'd0 : r_cnt + 5'd1;
            w_state_nxt = w_last_data ? COMMIT : DATA;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Frame datapath and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_sr   <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_addr <= w_addr_nxt;
            r_sr   <= w_sr_nxt;
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
        end
    end

    // Table storage: reset reloads the default function, commit writes one entry
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_LUTS; k++) begin
            if (!rst_n)                                   r_mem[k] <= RST_INIT;
            else if (w_wr && r_addr == ADDR_W'(k))        r_mem[k] <= r_sr;
        end
    end

    // Lookup mux; unpopulated addresses read as zero
    always_comb begin
        w_lk_bit = 1'b0;
        for (int k = 0; k < NUM_LUTS; k++)
            if (lk_addr == ADDR_W'(k)) w_lk_bit = r_mem[k][lk_in];
    end

    // Registered lookup result; reads pre-commit contents on a same-cycle write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lk_out       <= 1'b0;
            r_lk_out_valid <= 1'b0;
        end else begin
            r_lk_out_valid <= lk_valid;
            if (lk_valid) r_lk_out <= w_lk_bit;
        end
    end

endmodule

// File: tb/tb_lut5_cfg_loader.sv
// tb_lut5_cfg_loader: scoreboard bench for the LUT configuration loader (NUM_LUTS=6)
module tb_lut5_cfg_loader;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_sv = 1'b0;
    logic          cfg_sdi = 1'b0;
    logic          lk_valid = 1'b0;
    logic [AW-1:0] lk_addr = '0;
    logic [4:0]    lk_in = '0;
    logic          cfg_busy;
    logic          cfg_done;
    logic          cfg_err;
    logic          lk_out;
    logic          lk_out_valid;

    int   total = 0;
    int   bad = 0;
    logic q[$];

    lut5_cfg_loader #(.NUM_LUTS(6), .ADDR_W(AW), .RST_INIT(32'hFFFF8000)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_sv(cfg_sv), .cfg_sdi(cfg_sdi),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_in(lk_in),
        .lk_out(lk_out), .lk_out_valid(lk_out_valid)
    );

    always #5 clk = ~clk;

    // Scoreboard: every valid lookup result pops one expected value
    always @(negedge clk) begin
        logic e;
        if (lk_out_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL lk_unexpected: lk_out_valid=1 with no request pending");
            end else begin
                e = q.pop_front();
                if (lk_out !== e) begin
                    bad++;
                    $display("FAIL lk_result: got %b want %b", lk_out, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [AW-1:0] a, input logic [4:0] i, input logic e);
        lk_valid = 1'b1;
        lk_addr  = a;
        lk_in    = i;
        q.push_back(e);
        tick();
        lk_valid = 1'b0;
    endtask

    task automatic drain;
        repeat (2) tick();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL lk_drain: %0d results missing, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic send_bits(input logic [63:0] v, input int n, input bit gaps);
        for (int k = n - 1; k >= 0; k--) begin
            if (gaps && k != n - 1) begin
                repeat ($urandom_range(0, 2)) begin
                    cfg_sdi = 1'($urandom);
                    tick();
                end
            end
            cfg_sv  = 1'b1;
            cfg_sdi = v[k];
            tick();
            cfg_sv  = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [AW-1:0] a, input logic [31:0] d, input bit gaps);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        send_bits(64'({a, d}), AW + 32, gaps);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        total += 5;
        if (cfg_busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b want 0", cfg_busy); end
        if (cfg_done !== 1'b0)     begin bad++; $display("FAIL rst_done: got %b want 0", cfg_done); end
        if (cfg_err !== 1'b0)      begin bad++; $display("FAIL rst_err: got %b want 0", cfg_err); end
        if (lk_out !== 1'b0)       begin bad++; $display("FAIL rst_lk_out: got %b want 0", lk_out); end
        if (lk_out_valid !== 1'b0) begin bad++; $display("FAIL rst_lk_valid: got %b want 0", lk_out_valid); end
        rst_n = 1'b1;
        tick();
        lookup(3'd0, 5'b01111, 1'b1);
        lookup(3'd0, 5'b01110, 1'b0);
        lookup(3'd0, 5'b10000, 1'b1);
        lookup(3'd0, 5'b00000, 1'b0);
        drain();
    endtask

    task automatic test_normal;
        send_frame(3'd2, 32'h00000001, 1'b1);
        total += 2;
        if (cfg_busy !== 1'b1) begin bad++; $display("FAIL norm_commit_busy: got %b want 1", cfg_busy); end
        if (cfg_done !== 1'b0) begin bad++; $display("FAIL norm_early_done: got %b want 0", cfg_done); end
        tick();
        total += 2;
        if (cfg_done !== 1'b1) begin bad++; $display("FAIL norm_done: got %b want 1", cfg_done); end
        if (cfg_busy !== 1'b0) begin bad++; $display("FAIL norm_idle: got %b want 0", cfg_busy); end
        tick();
        total += 2;
        if (cfg_done !== 1'b0) begin bad++; $display("FAIL norm_done_pulse: got %b want 0", cfg_done); end
        if (cfg_err !== 1'b0)  begin bad++; $display("FAIL norm_err: got %b want 0", cfg_err); end
        lookup(3'd2, 5'd0, 1'b1);
        lookup(3'd2, 5'd1, 1'b0);
        lookup(3'd0, 5'd15, 1'b1);
        lookup(3'd0, 5'd14, 1'b0);
        lookup(3'd7, 5'd31, 1'b0);
        lookup(3'd6, 5'd31, 1'b0);
        drain();
    endtask

    task automatic test_hold;
        lookup(3'd0, 5'd16, 1'b1);
        lk_addr = 3'd2;
        lk_in   = 5'd1;
        repeat (3) tick();
        total += 2;
        if (lk_out !== 1'b1)       begin bad++; $display("FAIL hold_value: got %b want 1", lk_out); end
        if (lk_out_valid !== 1'b0) begin bad++; $display("FAIL hold_valid: got %b want 0", lk_out_valid); end
    endtask

    task automatic test_collision;
        send_frame(3'd2, 32'h00000000, 1'b0);
        lookup(3'd2, 5'd0, 1'b1);
        total++;
        if (cfg_done !== 1'b1) begin bad++; $display("FAIL coll_done: got %b want 1", cfg_done); end
        lookup(3'd2, 5'd0, 1'b0);
        drain();
    endtask

    task automatic test_abort;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        send_bits(64'({3'd4, 10'h3FF}), 13, 1'b1);
        cfg_start = 1'b1;
        cfg_sv    = 1'b1;
        cfg_sdi   = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_sv    = 1'b0;
        total += 2;
        if (cfg_err !== 1'b1)  begin bad++; $display("FAIL abort_err: got %b want 1", cfg_err); end
        if (cfg_busy !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b want 1", cfg_busy); end
        tick();
        total++;
        if (cfg_err !== 1'b0) begin bad++; $display("FAIL abort_err_pulse: got %b want 0", cfg_err); end
        send_bits(64'({3'd5, 32'hAAAAAAAA}), AW + 32, 1'b1);
        tick();
        total += 2;
        if (cfg_done !== 1'b1) begin bad++; $display("FAIL abort_next_done: got %b want 1", cfg_done); end
        if (cfg_err !== 1'b0)  begin bad++; $display("FAIL abort_next_err: got %b want 0", cfg_err); end
        lookup(3'd5, 5'd1, 1'b1);
        lookup(3'd5, 5'd0, 1'b0);
        lookup(3'd4, 5'd31, 1'b1);
        lookup(3'd4, 5'd14, 1'b0);
        drain();
    endtask

    task automatic test_invalid;
        send_frame(3'd7, 32'hFFFFFFFF, 1'b0);
        tick();
        total += 2;
        if (cfg_err !== 1'b1)  begin bad++; $display("FAIL inv_err: got %b want 1", cfg_err); end
        if (cfg_done !== 1'b0) begin bad++; $display("FAIL inv_done: got %b want 0", cfg_done); end
        tick();
        total++;
        if (cfg_err !== 1'b0) begin bad++; $display("FAIL inv_err_pulse: got %b want 0", cfg_err); end
        send_frame(3'd6, 32'hFFFFFFFF, 1'b0);
        tick();
        total += 2;
        if (cfg_err !== 1'b1)  begin bad++; $display("FAIL inv6_err: got %b want 1", cfg_err); end
        if (cfg_done !== 1'b0) begin bad++; $display("FAIL inv6_done: got %b want 0", cfg_done); end
        lookup(3'd5, 5'd1, 1'b1);
        lookup(3'd5, 5'd0, 1'b0);
        lookup(3'd2, 5'd31, 1'b0);
        lookup(3'd0, 5'd15, 1'b1);
        lookup(3'd1, 5'd0, 1'b0);
        lookup(3'd7, 5'd0, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        send_bits(64'({3'd3, 16'h0000}), AW + 16, 1'b0);
        rst_n = 1'b0;
        tick();
        total++;
        if (cfg_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", cfg_busy); end
        rst_n = 1'b1;
        send_bits(64'h0000_0000_000A_5A5A, 20, 1'b0);
        repeat (2) tick();
        total += 3;
        if (cfg_busy !== 1'b0) begin bad++; $display("FAIL midrst_stray_busy: got %b want 0", cfg_busy); end
        if (cfg_done !== 1'b0) begin bad++; $display("FAIL midrst_stray_done: got %b want 0", cfg_done); end
        if (cfg_err !== 1'b0)  begin bad++; $display("FAIL midrst_stray_err: got %b want 0", cfg_err); end
        lookup(3'd3, 5'd15, 1'b1);
        lookup(3'd3, 5'd14, 1'b0);
        lookup(3'd2, 5'd31, 1'b1);
        lookup(3'd5, 5'd1, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_hold();
        test_collision();
        test_abort();
        test_invalid();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
